multiply_tokens: RTL and testbench
==================================

MULTIPLY_TOKENS -- requirements
Module: multiply_tokens

Interface
REQ-001 Parameter MULT_W, default 3: width of the runtime multiplier input; legal 1..8.
REQ-002 Parameter COUNT_W, default 8: width of the pending-token counter; legal 2..16.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 a  input  1  input token; one token per cycle when high.
REQ-006 mult  input  MULT_W  output tokens generated per input token; sampled only in cycles with a=1; 0 means the token is dropped.
REQ-007 b_ready  input  1  downstream accepts an output token this cycle.
REQ-008 b  output  1  output token valid.
REQ-009 pending  output  COUNT_W  registered count of owed output tokens, P.
REQ-010 overflow  output  1  sticky flag; tokens were lost because P saturated.

Function
REQ-011 add = (a ? mult : 0), zero-extended to COUNT_W+1 bits; all arithmetic is unsigned, COUNT_W+1 bits, no truncation before the saturation check.
REQ-012 b = (P != 0) | (a & (mult != 0)), combinational, so b rises zero cycles after a; b is forced 0 while rst is low.
REQ-013 A token transfers when b & b_ready; sub = 1 on transfer, else 0.
REQ-014 next = P + add - sub; next never goes negative, because sub=1 implies P + add >= 1.
REQ-015 If next > 2^COUNT_W - 1: P <= 2^COUNT_W - 1 and overflow <= 1. Otherwise P <= next.
REQ-016 overflow, once set, holds at 1 until reset (see REQ-024 for the exception).
REQ-017 b_ready=0 stalls: P holds plus add; b stays high while P != 0.
REQ-018 A new token and a transfer in the same cycle: net change add-1; with mult=1 and b_ready=1, P is unchanged.
REQ-019 a=1 with mult=0: no change to P; b depends on P only.
REQ-020 Throughput: at most one output token per cycle; with b_ready held 1, output count = sum of mult over accepted a tokens, provided overflow=0.
REQ-021 pending = P, registered, and reflects the state after the previous edge.

Reset
REQ-022 While rst=0: P=0, pending=0, overflow=0, b=0; outputs take these values asynchronously on the rst falling edge.
REQ-023 A rst assertion mid-stream discards all owed tokens; after rst rises, the first edge is processed normally from P=0.

Configuration
REQ-024 Macro MULTIPLY_TOKENS_CLR_EN defined: adds input clr_overflow (1 bit, synchronous).
- clr_overflow=1 clears overflow on the next edge.
- If a saturation event happens in the same cycle, set wins and overflow stays 1.
- P is not affected by clr_overflow.
REQ-025 Macro MULTIPLY_TOKENS_CLR_EN undefined: the clr_overflow port does not exist, and only rst clears overflow.

Verification
REQ-026 Setup: reset, then mult=2, b_ready=1, 100 cycles of a random at 30% density, then a=0 for 200 cycles -> output token count = 2 x input token count, pending=0, overflow=0.
REQ-027 mult=1, b_ready=1, a=1 for 50 cycles -> b=1 every cycle including the first, pending stays 0.
REQ-028 b_ready=0, a=1 with mult=3 for 4 cycles -> pending=12, b=1; then a=0, b_ready=1 -> exactly 12 transfers, then b=0.
REQ-029 COUNT_W=8, mult=2, b_ready=1, a=1 for 1000 cycles -> overflow=1, pending=255 after cycle 255; overflow stays 1 after a drops.
REQ-030 a=1 with mult=0 for 20 cycles -> b=0 throughout, pending=0.
REQ-031 Reset mid-stream with pending=40, and (with MULTIPLY_TOKENS_CLR_EN) clr_overflow pulsed after overflow:
- after reset: pending=0, b=0, overflow=0;
- after the clr_overflow pulse: overflow=0 on the next edge, unless saturation occurs in that cycle.

Source files
------------

// File: rtl/multiply_tokens.sv
// Token multiplier: every accepted input token owes `mult` output tokens, drained one per cycle.
// Optional MULTIPLY_TOKENS_CLR_EN adds a synchronous clr_overflow input for the sticky overflow flag.
module multiply_tokens #(
  parameter int MULT_W  = 3,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a,
  input  logic [MULT_W-1:0]  mult,
  input  logic               b_ready,
`ifdef MULTIPLY_TOKENS_CLR_EN
  input  logic               clr_overflow,
`endif
  output logic               b,
  output logic [COUNT_W-1:0] pending,
  output logic               overflow
);

  // Sum is wide enough for both operands so a wide mult never truncates before the saturation test.
  localparam int SUM_W = ((COUNT_W > MULT_W) ? COUNT_W : MULT_W) + 1;
  localparam logic [SUM_W-1:0] P_MAX = {{(SUM_W-COUNT_W){1'b0}}, {COUNT_W{1'b1}}};

  logic [SUM_W-1:0] add, sub, nxt;
  logic             sat, ovf_clr;

  assign b   = rst & ((pending != '0) | (a & (mult != '0)));
  assign add = a ? SUM_W'(mult) : '0;
  assign sub = SUM_W'(b & b_ready);
  assign nxt = SUM_W'(pending) + add - sub;
  assign sat = nxt > P_MAX;

`ifdef MULTIPLY_TOKENS_CLR_EN
  assign ovf_clr = clr_overflow;
`else
  assign ovf_clr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= sat ? {COUNT_W{1'b1}} : nxt[COUNT_W-1:0];
      // A saturation in the same cycle as a clear keeps the flag set.
      overflow <= sat | (overflow & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_multiply_tokens.sv
// Randomised and directed bench for multiply_tokens against an integer token-count model.
module tb_multiply_tokens;
  localparam int MULT_W  = 3;
  localparam int COUNT_W = 8;
  localparam int PMAX    = (1 << COUNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               a = 1'b0;
  logic [MULT_W-1:0]  mult = '0;
  logic               b_ready = 1'b0;
`ifdef MULTIPLY_TOKENS_CLR_EN
  logic               clr = 1'b0;
`endif
  logic               b;
  logic [COUNT_W-1:0] pending;
  logic               overflow;

  int n_cmp = 0;
  int n_err = 0;
  int xfers = 0;
  int mP = 0;
  bit mOvf = 1'b0;

  multiply_tokens #(.MULT_W(MULT_W), .COUNT_W(COUNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .mult(mult),
    .b_ready(b_ready),
`ifdef MULTIPLY_TOKENS_CLR_EN
    .clr_overflow(clr),
`endif
    .b(b),
    .pending(pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an integer count of owed tokens, saturating at PMAX.
  always @(posedge clk or negedge rst) begin : model
    int add, nx;
    bit clr_now;
    if (!rst) begin
      mP   <= 0;
      mOvf <= 1'b0;
    end else begin
      add = a ? int'(mult) : 0;
      nx  = mP + add - ((((mP != 0) || (add != 0)) && b_ready) ? 1 : 0);
      clr_now = 1'b0;
`ifdef MULTIPLY_TOKENS_CLR_EN
      clr_now = clr;
`endif
      mP   <= (nx > PMAX) ? PMAX : nx;
      mOvf <= (nx > PMAX) || (mOvf && !clr_now);
    end
  end

  always @(negedge clk) begin
    check("b", int'(b), (rst && (mP != 0 || (a && mult != 0))) ? 1 : 0);
    check("pending", int'(pending), mP);
    check("overflow", int'(overflow), int'(mOvf));
    if (rst && b && b_ready) xfers++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input bit ai, input int mi, input bit bri);
    a = ai;
    mult = MULT_W'(mi);
    b_ready = bri;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int in_tok, x0;
    // reset holds everything at zero even with tokens offered
    drive(1, 3, 1);
    tick; tick;
    check("rst_pending", int'(pending), 0);
    check("rst_b", int'(b), 0);
    check("rst_ovf", int'(overflow), 0);
    rst = 1'b1;
    drive(0, 0, 1);
    tick;

    // mult=2, random 30% input density, then drain
    in_tok = 0;
    x0 = xfers;
    for (int i = 0; i < 100; i++) begin
      bit ai;
      ai = ($urandom_range(99) < 30);
      in_tok += int'(ai);
      drive(ai, 2, 1);
      tick;
    end
    drive(0, 0, 1);
    repeat (200) tick;
    check("r26_out_count", xfers - x0, 2 * in_tok);
    check("r26_pending", int'(pending), 0);
    check("r26_ovf", int'(overflow), 0);

    // mult=1 passes straight through with zero latency
    drive(1, 1, 1);
    for (int i = 0; i < 50; i++) begin
      #1 check("r27_b", int'(b), 1);
      tick;
    end
    check("r27_pending", int'(pending), 0);

    // mult=0 drops tokens
    drive(1, 0, 1);
    for (int i = 0; i < 20; i++) begin
      #1 check("r30_b", int'(b), 0);
      tick;
    end
    check("r30_pending", int'(pending), 0);

    // stall accumulation then exact drain
    drive(1, 3, 0);
    repeat (4) tick;
    check("r28_pending", int'(pending), 12);
    drive(0, 0, 1);
    x0 = xfers;
    #1 check("r28_b_hi", int'(b), 1);
    repeat (12) tick;
    check("r28_xfers", xfers - x0, 12);
    check("r28_b_lo", int'(b), 0);
    repeat (3) tick;
    check("r28_xfers_after", xfers - x0, 12);

    // saturation boundary: P climbs by one per cycle
    drive(1, 2, 1);
    repeat (255) tick;
    check("r29_p255", int'(pending), 255);
    check("r29_ovf_before", int'(overflow), 0);
    tick;
    check("r29_p_sat", int'(pending), 255);
    check("r29_ovf_set", int'(overflow), 1);
    repeat (744) tick;
    drive(0, 0, 1);
    repeat (300) tick;
    check("r29_ovf_sticky", int'(overflow), 1);
    check("r29_drained", int'(pending), 0);

`ifdef MULTIPLY_TOKENS_CLR_EN
    clr = 1'b1; tick; clr = 1'b0;
    check("clr_ovf", int'(overflow), 0);
    drive(1, 7, 0);
    repeat (37) tick;
    check("clr_sat_p", int'(pending), 255);
    check("clr_sat_ovf", int'(overflow), 1);
    clr = 1'b1; tick; clr = 1'b0;
    check("clr_vs_sat", int'(overflow), 1);
    drive(0, 0, 0);
    clr = 1'b1; tick; clr = 1'b0;
    check("clr_ovf2", int'(overflow), 0);
    check("clr_keeps_p", int'(pending), 255);
    drive(0, 0, 1);
    repeat (260) tick;
`endif

    // mid-stream reset discards owed tokens
    drive(1, 5, 0);
    repeat (8) tick;
    check("r31_p40", int'(pending), 40);
    rst = 1'b0;
    #1;
    check("r31_rst_p", int'(pending), 0);
    check("r31_rst_b", int'(b), 0);
    check("r31_rst_ovf", int'(overflow), 0);
    tick;
    rst = 1'b1;
    drive(1, 3, 0);
    tick;
    check("r31_first_edge", int'(pending), 3);
    drive(0, 0, 1);
    repeat (5) tick;

    // random soak with stall-heavy and drain-heavy phases
    for (int i = 0; i < 3000; i++) begin
      int pr;
      pr = ((i % 1000) < 500) ? 90 : 40;
      drive(bit'($urandom_range(1)), $urandom_range((1 << MULT_W) - 1), ($urandom_range(99) < pr));
`ifdef MULTIPLY_TOKENS_CLR_EN
      clr = ($urandom_range(19) == 0);
`endif
      rst = ($urandom_range(399) != 0);
      tick;
    end
    rst = 1'b1;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
